chip8_fetch_sequencer: RTL and testbench

- Instruction-fetch and program-counter controller for the CHIP-8 core.
- Reads two bytes per instruction from the 4 KiB byte memory and assembles them big-endian into a 16-bit word.
- Hands that word to decode/execute and waits for execute to report the PC action.
- Owns the PC and the 16-level subroutine return stack, so decode/execute never touch sequencing state.

---
 rtl/chip8_fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_chip8_fetch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_fetch_sequencer.sv
// CHIP-8 instruction fetch and program-counter sequencer.
// Fetches two bytes per instruction (big-endian), issues the word to
// decode/execute, then applies the PC action execute reports.
// Owns the PC and the return stack.
module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [2:0]  pc_op,
    input  logic [11:0] pc_target,
    output logic [11:0] pc,
    output logic [4:0]  sp,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam int unsigned SPW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]  SP_FULL = 5'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_JUMP = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HOLD = 3'd5
    } pc_op_t;

    state_t      state;
    state_t      state_nx;
    logic [11:0] pc_nx;
    logic [4:0]  sp_nx;
    logic [1:0]  fault_nx;
    logic        push;
    logic [11:0] stack [STACK_DEPTH];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, memory/issue outputs and PC/stack update decisions.
    always_comb begin
        state_nx    = state;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        pc_nx       = pc;
        sp_nx       = sp;
        fault_nx    = fault;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nx = FETCH_HI;
                end
            end
            FETCH_HI: begin
                mem_addr = pc;
                mem_rd   = 1'b1;
                if (mem_rvalid) begin
                    state_nx = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_addr = pc + 12'd1;
                mem_rd   = 1'b1;
                if (mem_rvalid) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                state_nx    = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    state_nx = run ? FETCH_HI : IDLE;
                    case (pc_op)
                        OP_SKIP: pc_nx = pc + 12'd4;
                        OP_JUMP: pc_nx = pc_target;
                        OP_CALL: begin
                            if (sp == SP_FULL) begin
                                fault_nx[0] = 1'b1;
                                state_nx    = HALT;
                            end else begin
                                push  = 1'b1;
                                sp_nx = sp + 5'd1;
                                pc_nx = pc_target;
                            end
                        end
                        OP_RET: begin
                            if (sp == 5'd0) begin
                                fault_nx[1] = 1'b1;
                                state_nx    = HALT;
                            end else begin
                                sp_nx = sp - 5'd1;
                                pc_nx = stack[SPW'(sp - 5'd1)];
                            end
                        end
                        OP_HOLD: pc_nx = pc;
                        default: pc_nx = pc + 12'd2;
                    endcase
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // PC, stack pointer, fault flags and instruction byte capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= PC_RESET;
            sp    <= '0;
            fault <= '0;
            instr <= '0;
        end else begin
            pc    <= pc_nx;
            sp    <= sp_nx;
            fault <= fault_nx;
            if (state == FETCH_HI && mem_rvalid) begin
                instr[15:8] <= mem_rdata;
            end
            if (state == FETCH_LO && mem_rvalid) begin
                instr[7:0] <= mem_rdata;
            end
        end
    end

    // Return-stack storage; contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            stack[SPW'(sp)] <= pc + 12'd2;
        end
    end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Scoreboard bench for chip8_fetch_sequencer: stimulus pushes expected
// read addresses and issued {pc, instr}; a monitor pops and compares.
module tb_chip8_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [2:0]  pc_op;
    logic [11:0] pc_target;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        halted;
    logic [1:0]  fault;

    int passes = 0;
    int total  = 0;

    logic [7:0]  mem [4096];
    int          lat      = 1;
    int          wait_cnt = 0;
    bit          stale    = 1'b0;
    logic [11:0] exp_addr_q [$];
    logic [27:0] exp_iss_q  [$];

    always #5 clk = ~clk;

    chip8_fetch_sequencer #(
        .PC_RESET   (12'h200),
        .STACK_DEPTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .pc_op      (pc_op),
        .pc_target  (pc_target),
        .pc         (pc),
        .sp         (sp),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory with programmable latency: rvalid appears 'lat' cycles after
    // a request starts; a new request starts after each accepted beat.
    always @(posedge clk) begin
        if (mem_rd && !mem_rvalid) wait_cnt++;
        else wait_cnt = 0;
        #2;
        if (stale) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'hEE;
        end else if (mem_rd && wait_cnt >= lat) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[mem_addr];
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mem_rd && mem_rvalid) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                $display("FAIL read_addr: unexpected read at %0h", mem_addr);
            end else begin
                check("read_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (instr_valid) begin
            if (exp_iss_q.size() == 0) begin
                total++;
                $display("FAIL issue: unexpected issue %0h at pc %0h", instr, pc);
            end else begin
                logic [27:0] e;
                e = exp_iss_q.pop_front();
                check("issue_pc", 32'(pc), 32'(e[27:16]));
                check("issue_instr", 32'(instr), 32'(e[15:0]));
            end
        end
    end

    task automatic wait_issue(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                ok = 1'b1;
                cycles = i;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL issue_timeout: got none expected instr_valid");
        end
    endtask

    task automatic do_instr(input logic [11:0] ipc, input logic [2:0] op, input logic [11:0] tgt,
                            input int l, input bit spurious, input bit drop_run,
                            input logic [11:0] npc, input logic [4:0] nsp, output int cycles);
        logic [11:0] ipc1;
        logic [15:0] word;
        bit ok;
        ipc1 = ipc + 12'd1;
        word = {mem[ipc], mem[ipc1]};
        lat  = l;
        exp_addr_q.push_back(ipc);
        exp_addr_q.push_back(ipc1);
        exp_iss_q.push_back({ipc, word});
        if (spurious) begin
            exec_done = 1'b1;
            pc_op     = 3'd2;
            pc_target = 12'hABC;
        end
        wait_issue(ok, cycles);
        exec_done = 1'b0;
        pc_op     = 3'd0;
        pc_target = 12'h000;
        if (ok) begin
            @(posedge clk); #1;
            check("valid_pulse", 32'(instr_valid), 32'd0);
            if (drop_run) run = 1'b0;
            @(posedge clk); #1;
            check("instr_hold", 32'(instr), 32'(word));
            exec_done = 1'b1;
            pc_op     = op;
            pc_target = tgt;
            @(posedge clk); #1;
            exec_done = 1'b0;
            pc_op     = 3'd0;
            pc_target = 12'h000;
            check("pc_after", 32'(pc), 32'(npc));
            check("sp_after", 32'(sp), 32'(nsp));
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        exec_done = 1'b0;
        stale = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic count_rd(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_rd || instr_valid) hits++;
        end
    endtask

    initial begin
        int cyc;
        int hits;
        bit found;
        rst = 1'b0; run = 1'b0; exec_done = 1'b0; pc_op = 3'd0; pc_target = 12'h000;
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a * 37 + 11);
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'h200);
        check("rst_sp", 32'(sp), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b1;

        // Main sequence: NEXT/SKIP/JUMP/CALL/RET/wrap/HOLD/reserved ops.
        run = 1'b1;
        do_instr(12'h200, 3'd0, 12'h000, 1, 0, 0, 12'h202, 5'd0, cyc);
        check("first_latency", 32'(cyc), 32'd5);
        check("first_instr", 32'(instr), 32'h1234);
        do_instr(12'h202, 3'd1, 12'h000, 0, 1, 0, 12'h206, 5'd0, cyc);
        do_instr(12'h206, 3'd2, 12'h3A0, 2, 0, 0, 12'h3A0, 5'd0, cyc);
        do_instr(12'h3A0, 3'd2, 12'h300, 3, 1, 0, 12'h300, 5'd0, cyc);
        do_instr(12'h300, 3'd3, 12'h400, 1, 0, 0, 12'h400, 5'd1, cyc);
        do_instr(12'h400, 3'd4, 12'h000, 0, 0, 0, 12'h302, 5'd0, cyc);
        do_instr(12'h302, 3'd2, 12'hFFE, 1, 0, 0, 12'hFFE, 5'd0, cyc);
        do_instr(12'hFFE, 3'd0, 12'h000, 2, 0, 0, 12'h000, 5'd0, cyc);
        do_instr(12'h000, 3'd2, 12'hFFF, 1, 0, 0, 12'hFFF, 5'd0, cyc);
        do_instr(12'hFFF, 3'd5, 12'h000, 1, 0, 0, 12'hFFF, 5'd0, cyc);
        do_instr(12'hFFF, 3'd5, 12'h000, 0, 0, 0, 12'hFFF, 5'd0, cyc);
        do_instr(12'hFFF, 3'd5, 12'h000, 3, 0, 0, 12'hFFF, 5'd0, cyc);
        do_instr(12'hFFF, 3'd0, 12'h000, 1, 0, 0, 12'h001, 5'd0, cyc);
        do_instr(12'h001, 3'd6, 12'h123, 1, 0, 0, 12'h003, 5'd0, cyc);
        do_instr(12'h003, 3'd7, 12'h456, 1, 0, 1, 12'h005, 5'd0, cyc);
        count_rd(5, hits);
        check("idle_after_run_drop", 32'(hits), 32'd0);
        check("idle_pc", 32'(pc), 32'h005);
        check("idle_halted", 32'(halted), 32'd0);

        // Reset in the middle of the low-byte fetch, then stale strobes.
        do_reset();
        lat = 3;
        exp_addr_q.push_back(12'h200);
        exp_addr_q.push_back(12'h201);
        exp_iss_q.push_back({12'h200, 16'h1234});
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 12'h201) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_fetch_lo", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_pc", 32'(pc), 32'h200);
        check("midrst_pending_reads", 32'(exp_addr_q.size()), 32'd1);
        check("midrst_pending_issue", 32'(exp_iss_q.size()), 32'd1);
        exp_addr_q.delete();
        exp_iss_q.delete();
        rst = 1'b1;
        stale = 1'b1;
        exec_done = 1'b1;
        pc_op = 3'd2;
        pc_target = 12'h777;
        count_rd(3, hits);
        @(posedge clk); #1;
        stale = 1'b0;
        exec_done = 1'b0;
        pc_op = 3'd0;
        pc_target = 12'h000;
        check("stale_no_activity", 32'(hits), 32'd0);
        check("stale_instr", 32'(instr), 32'd0);
        check("stale_pc", 32'(pc), 32'h200);

        // RET with an empty stack.
        run = 1'b1;
        do_instr(12'h200, 3'd4, 12'h000, 1, 0, 0, 12'h200, 5'd0, cyc);
        check("underflow_fault", 32'(fault), 32'd2);
        check("underflow_halted", 32'(halted), 32'd1);
        count_rd(5, hits);
        check("underflow_no_rd", 32'(hits), 32'd0);

        // Seventeen nested CALLs: the last one overflows.
        do_reset();
        check("reset_clears_fault", 32'(fault), 32'd0);
        check("reset_clears_halted", 32'(halted), 32'd0);
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [11:0] ipc;
            logic [11:0] tgt;
            ipc = (i == 0) ? 12'h200 : 12'(12'h500 + 16 * (i - 1));
            tgt = 12'(12'h500 + 16 * i);
            do_instr(ipc, 3'd3, tgt, 1, 0, 0, tgt, 5'(i + 1), cyc);
        end
        do_instr(12'h5F0, 3'd3, 12'h600, 0, 0, 0, 12'h5F0, 5'd16, cyc);
        check("overflow_fault", 32'(fault), 32'd1);
        check("overflow_halted", 32'(halted), 32'd1);
        count_rd(5, hits);
        check("overflow_no_rd", 32'(hits), 32'd0);
        check("overflow_pc_held", 32'(pc), 32'h5F0);
        do_reset();
        check("final_rst_fault", 32'(fault), 32'd0);
        check("final_rst_sp", 32'(sp), 32'd0);

        check("reads_drained", 32'(exp_addr_q.size()), 32'd0);
        check("issues_drained", 32'(exp_iss_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
